// File: rtl/aes_key_expansion.sv
// On-the-fly AES-128 key schedule feeding the encrypt core one round key per round; optional
// KEY_CACHE_EN macro adds an 11-entry round-key table. Latency: round key k is combinational
// from registered state the cycle after round k-1 is consumed (zero-wait). No backpressure.
module aes_key_expansion #(
    parameter int NR          = 10,
    parameter bit CHECK_ROUND = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] cipher_key,
    input  logic         cipher_new_en,
    input  logic         round_key_en,
    input  logic [3:0]   round_num,
    output logic [127:0] round_key,
    output logic         key_busy,
    output logic         key_sync_err
`ifdef KEY_CACHE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         cache_valid
`endif
);

    // Only the 10-round AES-128 schedule is implemented.
    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_key_expansion: only NR=10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] LAST_RND = 4'(NR);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   rnd_cnt_q, rnd_cnt_d;
    logic         sync_err_q, sync_err_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_t;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon_next;
    logic         consume;

    // Round function: next four words from the current key and round constant.
    always_comb begin
        w0        = key_q[127:96];
        w1        = key_q[95:64];
        w2        = key_q[63:32];
        w3        = key_q[31:0];
        rot_t     = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
        n0        = w0 ^ rot_t;
        n1        = w1 ^ n0;
        n2        = w2 ^ n1;
        n3        = w3 ^ n2;
        round_key = {n0, n1, n2, n3};
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    // Next-state: reseed beats everything; a consumed round in EXPAND advances the schedule.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        rcon_d     = rcon_q;
        rnd_cnt_d  = rnd_cnt_q;
        sync_err_d = sync_err_q;
        consume    = 1'b0;

        if (cipher_new_en) begin
            key_d      = cipher_key;
            rcon_d     = 8'h01;
            rnd_cnt_d  = 4'd1;
            sync_err_d = 1'b0;
            state_d    = ST_EXPAND;
        end else begin
            if (round_key_en &&
                ((state_q == ST_IDLE) || (CHECK_ROUND && (round_num != rnd_cnt_q)))) begin
                sync_err_d = 1'b1;
            end
            if (round_key_en && (state_q == ST_EXPAND)) begin
                consume = 1'b1;
                key_d   = round_key;
                if (rnd_cnt_q == LAST_RND) begin
                    state_d   = ST_IDLE;
                    rnd_cnt_d = 4'd0;
                end else begin
                    rcon_d    = rcon_next;
                    rnd_cnt_d = rnd_cnt_q + 4'd1;
                end
            end
        end
    end

    // Schedule state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            rcon_q     <= 8'h01;
            rnd_cnt_q  <= 4'd0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            rcon_q     <= rcon_d;
            rnd_cnt_q  <= rnd_cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign key_busy     = (state_q == ST_EXPAND);
    assign key_sync_err = sync_err_q;

`ifdef KEY_CACHE_EN
    logic [127:0] rk_tab_q [0:10];
    logic         tab_we;
    logic [3:0]   tab_widx;
    logic [127:0] tab_wdat;
    logic [127:0] rd_key_q, rd_key_d;
    logic         cache_valid_q, cache_valid_d;

    // Cache write port follows the schedule; read port sees pre-write contents.
    always_comb begin
        tab_we        = 1'b0;
        tab_widx      = 4'd0;
        tab_wdat      = '0;
        cache_valid_d = cache_valid_q;
        if (cipher_new_en) begin
            tab_we        = 1'b1;
            tab_widx      = 4'd0;
            tab_wdat      = cipher_key;
            cache_valid_d = 1'b0;
        end else if (consume) begin
            tab_we   = 1'b1;
            tab_widx = rnd_cnt_q;
            tab_wdat = round_key;
            if (rnd_cnt_q == LAST_RND) begin
                cache_valid_d = 1'b1;
            end
        end
        rd_key_d = (rd_idx <= 4'd10) ? rk_tab_q[rd_idx] : '0;
    end

    // Round-key table storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (tab_we) begin
            rk_tab_q[tab_widx] <= tab_wdat;
        end
    end

    // Registered read data and completion flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_key_q      <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            rd_key_q      <= rd_key_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    assign rd_key      = rd_key_q;
    assign cache_valid = cache_valid_q;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Randomised bench for aes_key_expansion with a FIPS-197-style key-schedule model.
// Expected round keys are queued at issue time and checked by a separate monitor.
// Status, error and cache behaviour are checked directly by the stimulus process.
module tb_aes_key_expansion;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] cipher_key;
    logic         cipher_new_en;
    logic         round_key_en;
    logic [3:0]   round_num;
    logic [127:0] round_key;
    logic         key_busy;
    logic         key_sync_err;
`ifdef KEY_CACHE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         cache_valid;
`endif

    aes_key_expansion dut (
        .clk           (clk),
        .reset         (reset),
        .cipher_key    (cipher_key),
        .cipher_new_en (cipher_new_en),
        .round_key_en  (round_key_en),
        .round_num     (round_num),
        .round_key     (round_key),
        .key_busy      (key_busy),
        .key_sync_err  (key_sync_err)
`ifdef KEY_CACHE_EN
        ,
        .rd_idx        (rd_idx),
        .rd_key        (rd_key),
        .cache_valid   (cache_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] exp_q [$];
    int           model_rnd = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++) if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Word-array key expansion w[0..43]
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1: pulse cipher_new_en for one cycle
    task automatic do_new(input logic [127:0] key, input logic with_en, input logic [3:0] num);
        cipher_key    = key;
        cipher_new_en = 1'b1;
        round_key_en  = with_en;
        round_num     = num;
        model_expand(key);
        model_rnd = 1;
        sync();
        cipher_new_en = 1'b0;
        round_key_en  = 1'b0;
    endtask

    task automatic drive_round(input logic [3:0] num);
        round_key_en = 1'b1;
        round_num    = num;
        if (model_rnd > 0) begin
            exp_q.push_back(exp_rk[model_rnd]);
            model_rnd = (model_rnd == 10) ? 0 : model_rnd + 1;
        end
    endtask

    task automatic do_round(input logic [3:0] num);
        drive_round(num);
        sync();
        round_key_en = 1'b0;
    endtask

`ifdef KEY_CACHE_EN
    task automatic cache_read(input logic [3:0] idx, input logic [127:0] exp, input string name);
        rd_idx = idx;
        sync();
        @(negedge clk);
        chk(name, rd_key, exp);
        sync();
    endtask
`endif

    // Monitor: every consumed round in EXPAND must present the next queued key
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && round_key_en && !cipher_new_en && key_busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got round_key %h with no expectation queued", round_key);
                end else begin
                    chk("sb_round_key", round_key, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    logic [127:0] k;

    initial begin
        reset = 1'b1; cipher_key = '0; cipher_new_en = 1'b0; round_key_en = 1'b0; round_num = 4'd0;
`ifdef KEY_CACHE_EN
        rd_idx = 4'd0;
`endif
        for (int x = 0; x < 256; x++) sbox_m[x] = sbox_calc(8'(x));

        // Reset state; idle round_key is the first round of an all-zero key
        model_expand('0);
        @(negedge clk);
        chk("rst_busy", {127'b0, key_busy}, 128'd0);
        chk("rst_err", {127'b0, key_sync_err}, 128'd0);
        chk("rst_round_key", round_key, exp_rk[1]);
        chk("rst_round_key_const", round_key, 128'h62636363626363636263636362636363);
`ifdef KEY_CACHE_EN
        chk("rst_rd_key", rd_key, 128'd0);
        chk("rst_cache_valid", {127'b0, cache_valid}, 128'd0);
`endif
        sync();
        reset = 1'b0;
        sync();

        // FIPS-197 vector, ten back-to-back rounds
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        do_new(k, 1'b0, 4'd0);
        @(negedge clk);
        chk("fips_r1_const", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_busy", {127'b0, key_busy}, 128'd1);
        sync();
        for (int r = 1; r <= 9; r++) do_round(4'(r));
        drive_round(4'd10);
        @(negedge clk);
        chk("fips_r10_const", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sync();
        round_key_en = 1'b0;
        @(negedge clk);
        chk("fips_busy_drop", {127'b0, key_busy}, 128'd0);
        chk("fips_err", {127'b0, key_sync_err}, 128'd0);
        sync();
`ifdef KEY_CACHE_EN
        cache_read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "cache_rd10");
        cache_read(4'd0, k, "cache_rd0");
        cache_read(4'd12, 128'd0, "cache_rd12");
        chk("cache_valid", {127'b0, cache_valid}, 128'd1);
`endif

        // Round-number mismatch sets a sticky error
        do_new({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0);
        do_round(4'd1);
        do_round(4'd3);
        @(negedge clk);
        chk("sync_err_set", {127'b0, key_sync_err}, 128'd1);
        sync();
        do_round(4'd3);
        do_round(4'd4);
        @(negedge clk);
        chk("sync_err_sticky", {127'b0, key_sync_err}, 128'd1);
        sync();
        do_new({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0);
        @(negedge clk);
        chk("sync_err_clear", {127'b0, key_sync_err}, 128'd0);
        sync();

        // Reset after round 5, then restart with the FIPS appendix key
        for (int r = 1; r <= 5; r++) do_round(4'(r));
        reset = 1'b1;
        model_rnd = 0;
        model_expand('0);
        @(negedge clk);
        chk("midrst_busy", {127'b0, key_busy}, 128'd0);
        chk("midrst_round_key", round_key, exp_rk[1]);
        sync();
        reset = 1'b0;
        sync();
        do_new(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'd0);
        @(negedge clk);
        chk("restart_r1_const", round_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        sync();
        do_round(4'd1);

        // Reseed wins over a simultaneous consume in round 4
        do_round(4'd2);
        do_round(4'd3);
        do_new({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd4);
        @(negedge clk);
        chk("reseed_err", {127'b0, key_sync_err}, 128'd0);
        chk("reseed_busy", {127'b0, key_busy}, 128'd1);
        chk("reseed_r1", round_key, exp_rk[1]);
        sync();
        for (int r = 1; r <= 10; r++) do_round(4'(r));
        @(negedge clk);
        chk("reseed_done_err", {127'b0, key_sync_err}, 128'd0);
        sync();

        // Random keys with random gaps between rounds
        for (int t = 0; t < 20; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            do_new(k, 1'b0, 4'd0);
            for (int r = 1; r <= 10; r++) begin
                while ($urandom_range(0, 2) == 0) sync();
                do_round(4'(r));
            end
            @(negedge clk);
            chk("rand_busy", {127'b0, key_busy}, 128'd0);
            chk("rand_err", {127'b0, key_sync_err}, 128'd0);
            sync();
`ifdef KEY_CACHE_EN
            begin
                int idx;
                idx = $urandom_range(0, 15);
                cache_read(4'(idx), (idx <= 10) ? exp_rk[idx] : 128'd0, "rand_cache");
            end
`endif
        end

        // Consuming while idle only raises the error
        do_round(4'd11);
        @(negedge clk);
        chk("idle_en_err", {127'b0, key_sync_err}, 128'd1);
        chk("idle_en_busy", {127'b0, key_busy}, 128'd0);
        sync();

        repeat (2) sync();
        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
